bmp_ram_arbiter: RTL and testbench
==================================

BMP_RAM_ARBITER -- requirements
Module: bmp_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 20: RAM address width in bits.
REQ-002 Parameter BYTE_WIDTH, default 8: RAM data width in bits.
REQ-003 Parameter MAX_LOCK, default 64: maximum consecutive grants to one locked requester; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents a RAM access this cycle.
REQ-007 reqN_wen  input  1  1 = write, 0 = read; qualified by reqN_valid.
REQ-008 reqN_lock  input  1  requester N asks to keep the port on its next request.
REQ-009 reqN_addr  input  ADDR_WIDTH  access address.
REQ-010 reqN_wdata  input  BYTE_WIDTH  write data.
REQ-011 reqN_grant  output  1  combinational; request accepted this cycle.
REQ-012 reqN_rvalid  output  1  read data for requester N on reqN_rdata.
REQ-013 reqN_rdata  output  BYTE_WIDTH  read data; equals RAM_out whenever reqN_rvalid=1.
REQ-014 RAM_ren  output  1  registered RAM read enable.
REQ-015 RAM_wen  output  1  registered RAM write enable.
REQ-016 RAM_addr  output  ADDR_WIDTH  registered RAM address.
REQ-017 RAM_in  output  BYTE_WIDTH  registered RAM write data.
REQ-018 RAM_out  input  BYTE_WIDTH  RAM read data, valid the cycle after RAM_ren is sampled high.

Function
REQ-019 At most one reqN_grant SHALL be high per cycle; reqN_grant SHALL never be high while reqN_valid=0.
REQ-020 Granted request in cycle T SHALL appear on RAM_ren/RAM_wen/RAM_addr/RAM_in in cycle T+1; with no grant in T, RAM_ren=RAM_wen=0 in T+1 (addr/data hold).
REQ-021 Granted read in cycle T SHALL produce reqN_rvalid=1 for exactly cycle T+2 on the issuing requester only; writes produce no rvalid.
REQ-022 Back-to-back grants SHALL be accepted every cycle; read returns are pipelined in issue order, with one rvalid per granted read.
REQ-023 Arbiter state: last_grant (1 bit), lock_owner_valid (1 bit), lock_owner (1 bit), lock_cnt (8 bits).
REQ-024 Single valid requester SHALL be granted immediately.
REQ-025 Both valid, no active lock: grant the requester != last_grant (round-robin).
REQ-026 Active lock (lock_owner_valid=1) with owner valid and lock_cnt < MAX_LOCK: grant the owner regardless of last_grant.
REQ-027 Active lock with owner valid=0: lock SHALL drop in that cycle and the other requester, if valid, is granted.
REQ-028 A grant with reqN_lock=1 SHALL set/keep lock_owner=N and increment lock_cnt (a new lock starts at lock_cnt=1); a grant with reqN_lock=0 SHALL clear lock_owner_valid and lock_cnt.
REQ-029 When lock_cnt reaches MAX_LOCK and the other requester is valid, the other requester SHALL be granted next and the lock cleared; if the other is idle, the owner continues and lock_cnt saturates at MAX_LOCK.
REQ-030 last_grant SHALL update to N on every grant to N and hold otherwise.
REQ-031 Requester holding valid without grant SHALL keep its command stable; the arbiter does not buffer ungranted requests.

Reset
REQ-032 While rst_n=0: RAM_ren=RAM_wen=0, RAM_addr=0, RAM_in=0, both rvalid=0, rdata pipeline cleared, last_grant=1, lock_owner_valid=0, lock_cnt=0; grants remain combinational but have no effect.
REQ-033 Reset asserted mid-transfer SHALL discard in-flight reads (no rvalid after release); first cycle after release: a tie grants requester 0.

Verification
REQ-034 Reset release, req0 read addr 0x00010 only -> req0_grant same cycle, RAM_ren=1/RAM_addr=0x00010 next cycle, req0_rvalid two cycles after grant with RAM_out value.
REQ-035 Both valid for 6 cycles, lock=0 -> grants alternate 0,1,0,1,0,1.
REQ-036 req0 lock=1 continuous with req1 valid, MAX_LOCK=4 -> req0 granted 4 consecutive cycles, then req1 granted, then alternation.
REQ-037 req0 write 0xAB at 0x00036 then req1 read 0x00036 in next cycle -> RAM_wen then RAM_ren on consecutive cycles; req1_rdata=0xAB, req0_rvalid stays 0.
REQ-038 rst_n pulsed low one cycle after a granted read -> no rvalid observed; RAM outputs 0 during reset.
REQ-039 Random valid/wen/lock on both ports for 10k cycles -> scoreboard: never two grants, every granted read returns exactly one rvalid at T+2, no requester waits more than MAX_LOCK+1 cycles.

Source files
------------

// File: rtl/bmp_ram_arbiter.sv
// Two-requester arbiter for a single-port byte RAM.
// Grants are combinational. The RAM command is registered one cycle after
// the grant. Read data returns to the issuing requester two cycles after
// the grant. Arbitration is round-robin, and a requester may hold the port
// with a bounded lock.
module bmp_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned MAX_LOCK   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_wen,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [BYTE_WIDTH-1:0] req0_wdata,
    output logic                  req0_grant,
    output logic                  req0_rvalid,
    output logic [BYTE_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_wen,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [BYTE_WIDTH-1:0] req1_wdata,
    output logic                  req1_grant,
    output logic                  req1_rvalid,
    output logic [BYTE_WIDTH-1:0] req1_rdata,

    output logic                  RAM_ren,
    output logic                  RAM_wen,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    output logic [BYTE_WIDTH-1:0] RAM_in,
    input  logic [BYTE_WIDTH-1:0] RAM_out
);

    localparam int unsigned CNT_WIDTH = 8;
    localparam logic [CNT_WIDTH-1:0] LOCK_MAX = CNT_WIDTH'(MAX_LOCK);

    // Arbiter state
    logic                  last_grant_q, last_grant_d;
    logic                  lock_valid_q, lock_valid_d;
    logic                  lock_owner_q, lock_owner_d;
    logic [CNT_WIDTH-1:0]  lock_cnt_q,   lock_cnt_d;

    // RAM command and read-return pipeline
    logic                  ram_ren_q,  ram_ren_d;
    logic                  ram_wen_q,  ram_wen_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [BYTE_WIDTH-1:0] ram_in_q,   ram_in_d;
    logic                  rd_id_q,    rd_id_d;
    logic                  rvalid0_q,  rvalid0_d;
    logic                  rvalid1_q,  rvalid1_d;

    // Combinational arbitration results
    logic                  grant0_c;
    logic                  grant1_c;
    logic                  gnt_any;
    logic                  gnt_id;
    logic                  sel_lock;
    logic                  sel_wen;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BYTE_WIDTH-1:0] sel_wdata;
    logic                  owner_valid;
    logic                  lock_hold;
    logic                  pick;

    // Grant selection: a single requester wins outright; on a tie the lock
    // owner wins while under budget, otherwise round-robin.
    always_comb begin
        grant0_c  = 1'b0;
        grant1_c  = 1'b0;
        pick      = 1'b0;
        lock_hold = lock_valid_q && (lock_cnt_q < LOCK_MAX);
        if (req0_valid && req1_valid) begin
            if (lock_valid_q) begin
                pick = lock_hold ? lock_owner_q : ~lock_owner_q;
            end else begin
                pick = ~last_grant_q;
            end
            grant0_c = ~pick;
            grant1_c = pick;
        end else begin
            grant0_c = req0_valid;
            grant1_c = req1_valid;
        end
    end

    // Mux the granted requester's command
    always_comb begin
        gnt_any     = grant0_c | grant1_c;
        gnt_id      = grant1_c;
        sel_lock    = gnt_id ? req1_lock  : req0_lock;
        sel_wen     = gnt_id ? req1_wen   : req0_wen;
        sel_addr    = gnt_id ? req1_addr  : req0_addr;
        sel_wdata   = gnt_id ? req1_wdata : req0_wdata;
        owner_valid = lock_owner_q ? req1_valid : req0_valid;
    end

    // Arbiter next state: round-robin pointer and lock bookkeeping
    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (gnt_any) begin
            last_grant_d = gnt_id;
            if (sel_lock) begin
                if (lock_valid_q && (lock_owner_q == gnt_id)) begin
                    // Same owner keeps the lock; count saturates at the budget
                    if (lock_cnt_q < LOCK_MAX) begin
                        lock_cnt_d = CNT_WIDTH'(lock_cnt_q + CNT_WIDTH'(1));
                    end
                end else begin
                    lock_valid_d = 1'b1;
                    lock_owner_d = gnt_id;
                    lock_cnt_d   = CNT_WIDTH'(1);
                end
            end else begin
                lock_valid_d = 1'b0;
                lock_cnt_d   = '0;
            end
        end else if (lock_valid_q && !owner_valid) begin
            // Owner went idle: release the port
            lock_valid_d = 1'b0;
            lock_cnt_d   = '0;
        end
    end

    // RAM command and return-tag next state; address/data hold when idle
    always_comb begin
        ram_ren_d  = gnt_any & ~sel_wen;
        ram_wen_d  = gnt_any &  sel_wen;
        ram_addr_d = ram_addr_q;
        ram_in_d   = ram_in_q;
        rd_id_d    = rd_id_q;
        if (gnt_any) begin
            ram_addr_d = sel_addr;
            ram_in_d   = sel_wdata;
            rd_id_d    = gnt_id;
        end
        rvalid0_d = ram_ren_q & ~rd_id_q;
        rvalid1_d = ram_ren_q &  rd_id_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= '0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_in_q     <= '0;
            rd_id_q      <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            ram_addr_q   <= ram_addr_d;
            ram_in_q     <= ram_in_d;
            rd_id_q      <= rd_id_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end

    assign req0_grant  = grant0_c;
    assign req1_grant  = grant1_c;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    // The RAM output arrives with the rvalid cycle, so it passes straight through
    assign req0_rdata  = rvalid0_q ? RAM_out : '0;
    assign req1_rdata  = rvalid1_q ? RAM_out : '0;
    assign RAM_ren     = ram_ren_q;
    assign RAM_wen     = ram_wen_q;
    assign RAM_addr    = ram_addr_q;
    assign RAM_in      = ram_in_q;

endmodule

// File: tb/tb_bmp_ram_arbiter.sv
// Directed and random-stimulus bench for bmp_ram_arbiter with MAX_LOCK=4.
module tb_bmp_ram_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned BW = 8;
    localparam int unsigned ML = 4;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_wen, req0_lock;
    logic [AW-1:0] req0_addr;
    logic [BW-1:0] req0_wdata;
    logic          req0_grant, req0_rvalid;
    logic [BW-1:0] req0_rdata;
    logic          req1_valid, req1_wen, req1_lock;
    logic [AW-1:0] req1_addr;
    logic [BW-1:0] req1_wdata;
    logic          req1_grant, req1_rvalid;
    logic [BW-1:0] req1_rdata;
    logic          RAM_ren, RAM_wen;
    logic [AW-1:0] RAM_addr;
    logic [BW-1:0] RAM_in;
    logic [BW-1:0] RAM_out;

    int checks;
    int errors;

    bmp_ram_arbiter #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_wen(req0_wen), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_grant(req0_grant),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_wen(req1_wen), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_grant(req1_grant),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .RAM_ren(RAM_ren), .RAM_wen(RAM_wen), .RAM_addr(RAM_addr),
        .RAM_in(RAM_in), .RAM_out(RAM_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple RAM: 256 bytes on the low address bits, one-cycle read latency,
    // preloaded with addr ^ 0x5A while reset is held
    logic [BW-1:0] mem [256];
    logic [BW-1:0] ram_out_r;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= BW'(i ^ 32'h5A);
        end else begin
            if (RAM_wen) mem[RAM_addr[7:0]] <= RAM_in;
            if (RAM_ren) ram_out_r <= mem[RAM_addr[7:0]];
        end
    end
    assign RAM_out = ram_out_r;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [BW-1:0] d);
        req0_valid = v; req0_wen = w; req0_lock = l; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [BW-1:0] d);
        req1_valid = v; req1_wen = w; req1_lock = l; req1_addr = a; req1_wdata = d;
    endtask

    task automatic idle();
        set0(1'b0, 1'b0, 1'b0, '0, '0);
        set1(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Leaves rst_n released just after a rising edge
    task automatic reset_dut();
        step();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [8:0] lock_seq;
    logic       g0, g1, gg0, gg1;
    logic       p1_0, p1_1, p2_0, p2_1;
    int         wait0, wait1;

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_ren",  32'(RAM_ren), 0);
        chk("rst_ram_wen",  32'(RAM_wen), 0);
        chk("rst_ram_addr", 32'(RAM_addr), 0);
        chk("rst_ram_in",   32'(RAM_in), 0);
        chk("rst_rvalid0",  32'(req0_rvalid), 0);
        chk("rst_rvalid1",  32'(req1_rvalid), 0);

        // Single read from req0 at 0x10
        step();
        rst_n = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 20'h00010, 8'h00);
        @(negedge clk);
        chk("rd_grant0", 32'(req0_grant), 1);
        chk("rd_grant1", 32'(req1_grant), 0);
        step();
        idle();
        @(negedge clk);
        chk("rd_ram_ren",  32'(RAM_ren), 1);
        chk("rd_ram_wen",  32'(RAM_wen), 0);
        chk("rd_ram_addr", 32'(RAM_addr), 32'h10);
        chk("rd_rvalid0_early", 32'(req0_rvalid), 0);
        step();
        @(negedge clk);
        chk("rd_rvalid0", 32'(req0_rvalid), 1);
        chk("rd_rdata0",  32'(req0_rdata), 32'h4A);
        chk("rd_rvalid1", 32'(req1_rvalid), 0);
        chk("rd_ram_ren_off", 32'(RAM_ren), 0);
        step();
        @(negedge clk);
        chk("rd_rvalid0_once", 32'(req0_rvalid), 0);

        // Round-robin with both requesters valid; a tie after reset goes to 0
        reset_dut();
        set0(1'b1, 1'b0, 1'b0, 20'h00020, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 20'h00021, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr_g0_%0d", i), 32'(req0_grant), 32'((i % 2) == 0));
            chk($sformatf("rr_g1_%0d", i), 32'(req1_grant), 32'((i % 2) == 1));
            step();
        end
        idle();
        repeat (3) step();

        // req0 locks for 4 grants, then req1, then alternation once req0 unlocks
        lock_seq = 9'b010101111;
        set0(1'b1, 1'b0, 1'b1, 20'h00022, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 20'h00023, 8'h00);
        for (int i = 0; i < 9; i++) begin
            if (i == 5) req0_lock = 1'b0;
            @(negedge clk);
            chk($sformatf("lock_g0_%0d", i), 32'(req0_grant), 32'(lock_seq[i]));
            chk($sformatf("lock_g1_%0d", i), 32'(req1_grant), 32'(!lock_seq[i]));
            step();
        end
        idle();
        step();

        // Lock saturates while req1 is idle, then req1 wins immediately
        set0(1'b1, 1'b0, 1'b1, 20'h00030, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("sat_g0_%0d", i), 32'(req0_grant), 1);
            step();
        end
        set1(1'b1, 1'b0, 1'b0, 20'h00031, 8'h00);
        @(negedge clk);
        chk("sat_g1", 32'(req1_grant), 1);
        chk("sat_g0", 32'(req0_grant), 0);
        step();
        idle();
        step();

        // Lock drops when its owner goes idle
        set0(1'b1, 1'b0, 1'b1, 20'h00040, 8'h00);
        @(negedge clk);
        chk("drop_g0", 32'(req0_grant), 1);
        step();
        idle();
        @(negedge clk);
        chk("drop_idle_g0", 32'(req0_grant), 0);
        chk("drop_idle_g1", 32'(req1_grant), 0);
        step();
        set0(1'b1, 1'b0, 1'b0, 20'h00041, 8'h00);
        set1(1'b1, 1'b0, 1'b0, 20'h00042, 8'h00);
        @(negedge clk);
        chk("drop_tie_g1", 32'(req1_grant), 1);
        chk("drop_tie_g0", 32'(req0_grant), 0);
        step();
        idle();
        repeat (2) step();

        // req0 writes 0xAB at 0x36, req1 reads it back on the next cycle
        set0(1'b1, 1'b1, 1'b0, 20'h00036, 8'hAB);
        @(negedge clk);
        chk("wr_grant0", 32'(req0_grant), 1);
        step();
        set0(1'b0, 1'b0, 1'b0, '0, '0);
        set1(1'b1, 1'b0, 1'b0, 20'h00036, 8'h00);
        @(negedge clk);
        chk("wr_grant1",   32'(req1_grant), 1);
        chk("wr_ram_wen",  32'(RAM_wen), 1);
        chk("wr_ram_ren",  32'(RAM_ren), 0);
        chk("wr_ram_addr", 32'(RAM_addr), 32'h36);
        chk("wr_ram_in",   32'(RAM_in), 32'hAB);
        step();
        idle();
        @(negedge clk);
        chk("wr_rd_ram_ren",  32'(RAM_ren), 1);
        chk("wr_rd_ram_wen",  32'(RAM_wen), 0);
        chk("wr_rd_ram_addr", 32'(RAM_addr), 32'h36);
        chk("wr_no_rvalid0",  32'(req0_rvalid), 0);
        step();
        @(negedge clk);
        chk("wr_rvalid1", 32'(req1_rvalid), 1);
        chk("wr_rdata1",  32'(req1_rdata), 32'hAB);
        chk("wr_rvalid0", 32'(req0_rvalid), 0);
        step();

        // Reset one cycle after a granted read discards it
        set0(1'b1, 1'b0, 1'b0, 20'h00050, 8'h00);
        @(negedge clk);
        chk("mr_grant0", 32'(req0_grant), 1);
        step();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_ram_ren",  32'(RAM_ren), 0);
        chk("mr_ram_wen",  32'(RAM_wen), 0);
        chk("mr_ram_addr", 32'(RAM_addr), 0);
        chk("mr_ram_in",   32'(RAM_in), 0);
        chk("mr_rvalid0_a", 32'(req0_rvalid), 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rvalid0_b", 32'(req0_rvalid), 0);
        step();
        @(negedge clk);
        chk("mr_rvalid0_c", 32'(req0_rvalid), 0);
        step();
        step();

        // Random traffic; an ungranted request is held stable until granted
        p1_0 = 1'b0; p1_1 = 1'b0; p2_0 = 1'b0; p2_1 = 1'b0;
        gg0 = 1'b0; gg1 = 1'b0;
        wait0 = 0; wait1 = 0;
        for (int n = 0; n < 10000; n++) begin
            if (!req0_valid || gg0) begin
                set0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                     BW'($urandom_range(0, 255)));
            end
            if (!req1_valid || gg1) begin
                set1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)),
                     BW'($urandom_range(0, 255)));
            end
            @(negedge clk);
            g0 = req0_grant;
            g1 = req1_grant;
            chk("rnd_onehot",   32'(g0 & g1), 0);
            chk("rnd_g0_valid", 32'(g0 & ~req0_valid), 0);
            chk("rnd_g1_valid", 32'(g1 & ~req1_valid), 0);
            chk("rnd_rvalid0",  32'(req0_rvalid), 32'(p2_0));
            chk("rnd_rvalid1",  32'(req1_rvalid), 32'(p2_1));
            if (req0_rvalid) chk("rnd_rdata0", 32'(req0_rdata), 32'(RAM_out));
            if (req1_rvalid) chk("rnd_rdata1", 32'(req1_rdata), 32'(RAM_out));
            wait0 = (req0_valid && !g0) ? wait0 + 1 : 0;
            wait1 = (req1_valid && !g1) ? wait1 + 1 : 0;
            chk("rnd_wait0", 32'(wait0 > int'(ML + 1)), 0);
            chk("rnd_wait1", 32'(wait1 > int'(ML + 1)), 0);
            p2_0 = p1_0;
            p2_1 = p1_1;
            p1_0 = g0 & ~req0_wen;
            p1_1 = g1 & ~req1_wen;
            gg0 = g0;
            gg1 = g1;
            step();
        end
        idle();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
